// File: rtl/neuron.sv
// neuron -- single trainable neuron with serial multiply-accumulate.
//
// Forward pass: latches N unsigned Q0.8 inputs, accumulates w[i]*x[i] one
// index per cycle, then presents sat16(acc >>> 8) as a signed Q8.8 result.
// Training pass (when en is high at the result handshake): accepts a
// signed Q8.8 gradient, and for each index computes the upstream feedback
// from the old weight and then applies the weight update.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                training enable, sampled on the result handshake
//   arg_stb/rdy/dat   input vector handshake (N x 8-bit unsigned)
//   res_stb/rdy/dat   weighted-sum result handshake (16-bit signed Q8.8)
//   err_stb/rdy/dat   gradient handshake (16-bit signed Q8.8)
//   fbk_stb/rdy/dat   per-input feedback handshake (N x 16-bit signed Q8.8)
module neuron #(
    parameter int N    = 4,
    parameter int RATE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            arg_stb,
    input  logic [8*N-1:0]  arg_dat,
    output logic            arg_rdy,
    output logic            res_stb,
    output logic [15:0]     res_dat,
    input  logic            res_rdy,
    input  logic            err_stb,
    input  logic [15:0]     err_dat,
    output logic            err_rdy,
    output logic            fbk_stb,
    output logic [16*N-1:0] fbk_dat,
    input  logic            fbk_rdy
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 16;
    localparam int PROD_W = COEF_W + DATA_W + 1;
    localparam int IDX_W  = $clog2(N);
    localparam int ACC_W  = PROD_W + $clog2(N);

    typedef enum logic [2:0] {ARG, MAC, RES, ERR, UPD, FBK} state_t;

    state_t                     state, state_next;
    logic        [IDX_W-1:0]    idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [COEF_W-1:0]   err;
    logic signed [COEF_W-1:0]   w   [N];
    logic signed [COEF_W-1:0]   fb  [N];
    logic        [DATA_W-1:0]   x   [N];

    logic                       last;
    logic signed [COEF_W-1:0]   mul_a;
    logic signed [DATA_W:0]     mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   delta;
    logic signed [31:0]         fb_prod;

    // Clamp a wide signed value to the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [39:0] v);
        if (v > 40'sd32767)
            return 16'sh7FFF;
        else if (v < -40'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    assign last = (idx == IDX_W'(N - 1));

    // One 16x9 multiplier serves both passes: weight*x while accumulating,
    // err*x while updating weights. x is zero-extended to keep it unsigned.
    assign mul_a   = (state == UPD) ? err : w[idx];
    assign mul_b   = {1'b0, x[idx]};
    assign prod    = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign delta   = prod >>> (8 + RATE);
    assign fb_prod = 32'(err) * 32'(w[idx]);

    assign arg_rdy = (state == ARG);
    assign res_stb = (state == RES);
    assign err_rdy = (state == ERR);
    assign fbk_stb = (state == FBK);
    assign res_dat = sat16(40'(acc >>> 8));

    for (genvar g = 0; g < N; g++) begin : g_fbk
        assign fbk_dat[16*g +: 16] = fb[g];
    end

    always_comb begin
        state_next = state;
        case (state)
            ARG: if (arg_stb) state_next = MAC;
            MAC: if (last) state_next = RES;
            RES: if (res_rdy) state_next = en ? ERR : ARG;
            ERR: if (err_stb) state_next = UPD;
            UPD: if (last) state_next = FBK;
            FBK: if (fbk_rdy) state_next = ARG;
            default: state_next = ARG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARG;
            idx   <= '0;
            acc   <= '0;
            err   <= '0;
            for (int i = 0; i < N; i++) begin
                w[i]  <= '0;
                fb[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                ARG: if (arg_stb) begin
                    acc <= '0;
                    idx <= '0;
                end
                // Stage MAC: accumulate one product per cycle
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= last ? '0 : idx + 1'b1;
                end
                ERR: if (err_stb) begin
                    err <= err_dat;
                    idx <= '0;
                end
                // Stage UPD: feedback uses the weight before it is overwritten
                UPD: begin
                    fb[idx] <= sat16(40'(fb_prod >>> 8));
                    w[idx]  <= sat16(40'(w[idx]) - 40'(delta));
                    idx     <= last ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Input vector register: data only, no reset needed
    always_ff @(posedge clk) begin
        if (state == ARG && arg_stb) begin
            for (int i = 0; i < N; i++)
                x[i] <= arg_dat[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_neuron.sv
module tb_neuron;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            arg_stb = 1'b0;
    logic [8*N-1:0]  arg_dat = '0;
    logic            res_rdy = 1'b0;
    logic            err_stb = 1'b0;
    logic [15:0]     err_dat = '0;
    logic            fbk_rdy = 1'b0;

    logic            arg_rdy, res_stb, err_rdy, fbk_stb;
    logic [15:0]     res_dat;
    logic [16*N-1:0] fbk_dat;
    logic            arg_rdy_r2, res_stb_r2, err_rdy_r2, fbk_stb_r2;
    logic [15:0]     res_dat_r2;
    logic [16*N-1:0] fbk_dat_r2;

    int n_cmp = 0;
    int n_fail = 0;

    neuron #(.N(N), .RATE(0)) dut (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
        .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy)
    );

    // Second instance with RATE=2 runs the identical handshake sequence.
    neuron #(.N(N), .RATE(2)) dut_r2 (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy_r2),
        .res_stb(res_stb_r2), .res_dat(res_dat_r2), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy_r2),
        .fbk_stb(fbk_stb_r2), .fbk_dat(fbk_dat_r2), .fbk_rdy(fbk_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Drivers: perform one handshake each; a stalled handshake is a failure.
    task automatic send_arg(input logic [8*N-1:0] x);
        int n = 0;
        arg_stb = 1'b1;
        arg_dat = x;
        while (!arg_rdy && n < 100) begin step(); n++; end
        if (!arg_rdy) begin
            n_cmp++; n_fail++;
            $display("FAIL arg_timeout: arg_rdy=%b required 1", arg_rdy);
        end
        step();
        arg_stb = 1'b0;
    endtask

    task automatic take_res(input logic en_v, output logic [15:0] r, output logic [15:0] r2);
        int n = 0;
        en = en_v;
        res_rdy = 1'b1;
        while (!res_stb && n < 100) begin step(); n++; end
        if (!res_stb) begin
            n_cmp++; n_fail++;
            $display("FAIL res_timeout: res_stb=%b required 1", res_stb);
        end
        r = res_dat;
        r2 = res_dat_r2;
        step();
        res_rdy = 1'b0;
        en = 1'b0;
    endtask

    task automatic send_err(input logic [15:0] e);
        int n = 0;
        err_stb = 1'b1;
        err_dat = e;
        while (!err_rdy && n < 100) begin step(); n++; end
        if (!err_rdy) begin
            n_cmp++; n_fail++;
            $display("FAIL err_timeout: err_rdy=%b required 1", err_rdy);
        end
        step();
        err_stb = 1'b0;
    endtask

    task automatic take_fbk(output logic [16*N-1:0] f, output logic [16*N-1:0] f2);
        int n = 0;
        fbk_rdy = 1'b1;
        while (!fbk_stb && n < 100) begin step(); n++; end
        if (!fbk_stb) begin
            n_cmp++; n_fail++;
            $display("FAIL fbk_timeout: fbk_stb=%b required 1", fbk_stb);
        end
        f = fbk_dat;
        f2 = fbk_dat_r2;
        step();
        fbk_rdy = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (arg_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_arg_rdy: got %b want 1", arg_rdy); end
        n_cmp++; if (res_stb !== 1'b0) begin n_fail++; $display("FAIL rst_res_stb: got %b want 0", res_stb); end
        n_cmp++; if (err_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_err_rdy: got %b want 0", err_rdy); end
        n_cmp++; if (fbk_stb !== 1'b0) begin n_fail++; $display("FAIL rst_fbk_stb: got %b want 0", fbk_stb); end
        n_cmp++; if (fbk_dat !== 64'h0) begin n_fail++; $display("FAIL rst_fbk_dat: got %h want 0", fbk_dat); end
        n_cmp++; if (res_dat !== 16'h0) begin n_fail++; $display("FAIL rst_res_dat: got %h want 0", res_dat); end
    endtask

    task automatic test_inference();
        logic [15:0] r, r2;
        send_arg({8'h00, 8'h01, 8'h80, 8'hFF});
        // now in cycle t+1; result must appear in cycle t+N+1
        repeat (N - 1) step();
        n_cmp++; if (res_stb !== 1'b0) begin n_fail++; $display("FAIL lat_early: res_stb=%b want 0", res_stb); end
        step();
        n_cmp++; if (res_stb !== 1'b1) begin n_fail++; $display("FAIL lat_res: res_stb=%b want 1", res_stb); end
        take_res(1'b0, r, r2);
        n_cmp++; if (r !== 16'h0000) begin n_fail++; $display("FAIL inf_zero: got %h want 0000", r); end
        n_cmp++; if (arg_rdy !== 1'b1) begin n_fail++; $display("FAIL inf_arg_rdy: got %b want 1", arg_rdy); end
        repeat (3) step();
        n_cmp++; if (err_rdy !== 1'b0) begin n_fail++; $display("FAIL inf_no_err: err_rdy=%b want 0", err_rdy); end
    endtask

    task automatic test_train_negative();
        logic [15:0] r, r2;
        logic [16*N-1:0] f, f2;
        send_arg(32'h0000_00FF);
        take_res(1'b1, r, r2);
        n_cmp++; if (err_rdy !== 1'b1) begin n_fail++; $display("FAIL tr_err_rdy: got %b want 1", err_rdy); end
        send_err(16'hFF00);
        repeat (N - 1) step();
        n_cmp++; if (fbk_stb !== 1'b0) begin n_fail++; $display("FAIL lat_fbk_early: fbk_stb=%b want 0", fbk_stb); end
        step();
        n_cmp++; if (fbk_stb !== 1'b1) begin n_fail++; $display("FAIL lat_fbk: fbk_stb=%b want 1", fbk_stb); end
        take_fbk(f, f2);
        n_cmp++; if (f !== 64'h0) begin n_fail++; $display("FAIL tr_fbk0: got %h want 0", f); end
        send_arg(32'h0000_0080);
        take_res(1'b0, r, r2);
        n_cmp++; if (r !== 16'h007F) begin n_fail++; $display("FAIL tr_w255: got %h want 007F", r); end
        // RATE=2 instance: w0 = 64, 64*128 >>> 8 = 32
        n_cmp++; if (r2 !== 16'h0020) begin n_fail++; $display("FAIL tr_r2_w64: got %h want 0020", r2); end
    endtask

    task automatic test_train_positive();
        logic [15:0] r, r2;
        logic [16*N-1:0] f, f2;
        send_arg(32'h0000_0080);
        take_res(1'b1, r, r2);
        n_cmp++; if (r !== 16'h007F) begin n_fail++; $display("FAIL tp_res: got %h want 007F", r); end
        send_err(16'h0100);
        take_fbk(f, f2);
        n_cmp++; if (f !== {16'h0, 16'h0, 16'h0, 16'h00FF}) begin n_fail++; $display("FAIL tp_fbk: got %h want 00FF in word 0", f); end
        send_arg(32'h0000_00FF);
        take_res(1'b0, r, r2);
        n_cmp++; if (r !== 16'h007E) begin n_fail++; $display("FAIL tp_w127: got %h want 007E", r); end
    endtask

    task automatic test_saturation();
        logic [15:0] r, r2;
        logic [16*N-1:0] f, f2;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send_arg(32'hFFFF_FFFF);
            take_res(1'b1, r, r2);
            send_err(16'h8000);
            take_fbk(f, f2);
            if (k == 0) begin
                n_cmp++; if (f !== 64'h0) begin n_fail++; $display("FAIL sat_fbk1: got %h want 0", f); end
            end else begin
                n_cmp++; if (r !== 16'h7FFF) begin n_fail++; $display("FAIL sat_res2: got %h want 7FFF", r); end
                n_cmp++; if (f !== {4{16'h8000}}) begin n_fail++; $display("FAIL sat_fbk2: got %h want 8000 x4", f); end
            end
        end
        send_arg(32'hFFFF_FFFF);
        take_res(1'b0, r, r2);
        n_cmp++; if (r !== 16'h7FFF) begin n_fail++; $display("FAIL sat_res: got %h want 7FFF", r); end
        // weights are now 32767: x0=1 alone gives 32767 >>> 8 = 127
        send_arg(32'h0000_0001);
        take_res(1'b0, r, r2);
        n_cmp++; if (r !== 16'h007F) begin n_fail++; $display("FAIL sat_w32767: got %h want 007F", r); end
    endtask

    task automatic test_back_pressure();
        logic [15:0] r, r2;
        logic [16*N-1:0] f, f2;
        int bad;
        send_arg(32'h0000_0001);
        repeat (N + 1) step();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (res_stb !== 1'b1 || res_dat !== 16'h007F) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_res_hold: %0d unstable cycles, want 0 (res_dat %h want 007F)", bad, res_dat); end
        take_res(1'b1, r, r2);
        send_err(16'h0100);
        repeat (N + 1) step();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (fbk_stb !== 1'b1 || fbk_dat !== {4{16'h7FFF}}) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_fbk_hold: %0d unstable cycles, want 0 (fbk %h want 7FFF x4)", bad, fbk_dat); end
        take_fbk(f, f2);
        // w0 is now 32766: 32766*255 >>> 8 = 32638 = 0x7F7E... saturated sum anyway; check x1 path
        send_arg(32'h0000_0100);
        take_res(1'b1, r, r2);
        n_cmp++; if (r !== 16'h007F) begin n_fail++; $display("FAIL bp_w1: got %h want 007F", r); end
        send_err(16'h0100);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (arg_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_upd_arg_rdy: got %b want 1", arg_rdy); end
        n_cmp++; if (fbk_stb !== 1'b0) begin n_fail++; $display("FAIL rst_upd_fbk_stb: got %b want 0", fbk_stb); end
        n_cmp++; if (fbk_dat !== 64'h0) begin n_fail++; $display("FAIL rst_upd_fbk_dat: got %h want 0", fbk_dat); end
        send_arg(32'hFFFF_FFFF);
        take_res(1'b0, r, r2);
        n_cmp++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rst_upd_res: got %h want 0000", r); end
    endtask

    task automatic test_rate();
        logic [15:0] r, r2;
        logic [16*N-1:0] f, f2;
        do_reset();
        send_arg(32'h0000_00FF);
        take_res(1'b1, r, r2);
        send_err(16'hFF00);
        take_fbk(f, f2);
        send_arg(32'h0000_00FF);
        take_res(1'b0, r, r2);
        n_cmp++; if (r2 !== 16'h003F) begin n_fail++; $display("FAIL rate2_res: got %h want 003F", r2); end
        n_cmp++; if (r !== 16'h00FE) begin n_fail++; $display("FAIL rate0_res: got %h want 00FE", r); end
    endtask

    initial begin
        test_reset();
        test_inference();
        test_train_negative();
        test_train_positive();
        test_saturation();
        test_back_pressure();
        test_rate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end
endmodule
